// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for the multicycle processor datapath.
// Sequences fetch, decode, execute, memory and writeback over several clocks.
// Outputs are decoded from the current state, qualified by opcode, funct, zero
// and mem_ready where the action depends on them.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   opcode, funct       IR[31:26] / IR[5:0]
//   zero                ALU zero flag (branch resolution)
//   mem_ready           memory access completes this cycle
//   pc_en, pc_src       PC load enable and source select
//   iord                memory address select (0 PC, 1 ALUOut)
//   mem_write, ir_write memory write strobe, IR load enable
//   reg_dst, mem_to_reg register file destination and write-data selects
//   reg_write           register file write enable
//   alu_src_a/b, alu_ctl ALU operand selects and operation
//   ext_sel             immediate extender: 1 sign, 0 zero
//   retire, illegal     completion / undefined-instruction pulses
//   state_o             current state, for debug
module multicycle_ctrl #(
   parameter int unsigned OPW = 6,
   parameter int unsigned STW = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [OPW-1:0] opcode,
   input  logic [OPW-1:0] funct,
   input  logic           zero,
   input  logic           mem_ready,
   output logic           pc_en,
   output logic [1:0]     pc_src,
   output logic           iord,
   output logic           mem_write,
   output logic           ir_write,
   output logic           reg_dst,
   output logic           mem_to_reg,
   output logic           reg_write,
   output logic           alu_src_a,
   output logic [1:0]     alu_src_b,
   output logic [2:0]     alu_ctl,
   output logic           ext_sel,
   output logic           retire,
   output logic           illegal,
   output logic [STW-1:0] state_o
);

   typedef enum logic [3:0] {
      StFetch  = 4'd0,
      StDecode = 4'd1,
      StMemAdr = 4'd2,
      StMemRd  = 4'd3,
      StMemWb  = 4'd4,
      StMemWr  = 4'd5,
      StExec   = 4'd6,
      StAluWb  = 4'd7,
      StBranch = 4'd8,
      StIExec  = 4'd9,
      StIWb    = 4'd10,
      StJump   = 4'd11
   } state_e;

   localparam logic [OPW-1:0] OpRtype = OPW'(6'b000000);
   localparam logic [OPW-1:0] OpLw    = OPW'(6'b100011);
   localparam logic [OPW-1:0] OpSw    = OPW'(6'b101011);
   localparam logic [OPW-1:0] OpBeq   = OPW'(6'b000100);
   localparam logic [OPW-1:0] OpAddi  = OPW'(6'b001000);
   localparam logic [OPW-1:0] OpOri   = OPW'(6'b001101);
   localparam logic [OPW-1:0] OpJ     = OPW'(6'b000010);

   localparam logic [OPW-1:0] FnAdd = OPW'(6'b100000);
   localparam logic [OPW-1:0] FnSub = OPW'(6'b100010);
   localparam logic [OPW-1:0] FnAnd = OPW'(6'b100100);
   localparam logic [OPW-1:0] FnOr  = OPW'(6'b100101);
   localparam logic [OPW-1:0] FnSlt = OPW'(6'b101010);

   localparam logic [2:0] AluAdd = 3'b010;
   localparam logic [2:0] AluSub = 3'b110;
   localparam logic [2:0] AluAnd = 3'b000;
   localparam logic [2:0] AluOr  = 3'b001;
   localparam logic [2:0] AluSlt = 3'b111;

   state_e state_q, state_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   assign state_o = STW'(state_q);

   always_comb begin
      state_d    = state_q;
      pc_en      = 1'b0;
      pc_src     = 2'b00;
      iord       = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_ctl    = AluAdd;
      ext_sel    = 1'b1;
      retire     = 1'b0;
      illegal    = 1'b0;

      case (state_q)
         StFetch: begin
            // PC + 4 computed while the instruction word is read
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_en     = mem_ready;
            if (mem_ready) begin
               state_d = StDecode;
            end
         end
         StDecode: begin
            // Branch target precompute: PC + (imm << 2)
            alu_src_b = 2'b11;
            if (opcode == OpLw || opcode == OpSw) begin
               state_d = StMemAdr;
            end else if (opcode == OpRtype) begin
               state_d = StExec;
            end else if (opcode == OpBeq) begin
               state_d = StBranch;
            end else if (opcode == OpAddi || opcode == OpOri) begin
               state_d = StIExec;
            end else if (opcode == OpJ) begin
               state_d = StJump;
            end else begin
               illegal = 1'b1;
               state_d = StFetch;
            end
         end
         StMemAdr: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = (opcode == OpLw) ? StMemRd : StMemWr;
         end
         StMemRd: begin
            iord = 1'b1;
            if (mem_ready) begin
               state_d = StMemWb;
            end
         end
         StMemWb: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            retire     = 1'b1;
            state_d    = StFetch;
         end
         StMemWr: begin
            iord      = 1'b1;
            mem_write = 1'b1;
            retire    = mem_ready;
            if (mem_ready) begin
               state_d = StFetch;
            end
         end
         StExec: begin
            alu_src_a = 1'b1;
            state_d   = StAluWb;
            if (funct == FnAdd) begin
               alu_ctl = AluAdd;
            end else if (funct == FnSub) begin
               alu_ctl = AluSub;
            end else if (funct == FnAnd) begin
               alu_ctl = AluAnd;
            end else if (funct == FnOr) begin
               alu_ctl = AluOr;
            end else if (funct == FnSlt) begin
               alu_ctl = AluSlt;
            end else begin
               illegal = 1'b1;
               state_d = StFetch;
            end
         end
         StAluWb: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
            retire    = 1'b1;
            state_d   = StFetch;
         end
         StBranch: begin
            alu_src_a = 1'b1;
            alu_ctl   = AluSub;
            pc_src    = 2'b01;
            pc_en     = zero;
            retire    = 1'b1;
            state_d   = StFetch;
         end
         StIExec: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            if (opcode == OpOri) begin
               alu_ctl = AluOr;
               ext_sel = 1'b0;
            end
            state_d = StIWb;
         end
         StIWb: begin
            // ALU result must stay valid for the write, so hold IEXEC's op
            reg_write = 1'b1;
            retire    = 1'b1;
            if (opcode == OpOri) begin
               alu_ctl = AluOr;
               ext_sel = 1'b0;
            end
            state_d = StFetch;
         end
         StJump: begin
            pc_src  = 2'b10;
            pc_en   = 1'b1;
            retire  = 1'b1;
            state_d = StFetch;
         end
         default: begin
            state_d = StFetch;
         end
      endcase

      // Reset abandons any in-flight instruction without side effects
      if (rst) begin
         pc_en     = 1'b0;
         ir_write  = 1'b0;
         mem_write = 1'b0;
         reg_write = 1'b0;
         retire    = 1'b0;
         illegal   = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl. Each instruction is expanded into the list of
// cycles it must take (with chosen memory stalls), each cycle carrying the
// inputs to drive and the outputs expected. A compare loop checks every cycle.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode, funct;
   logic       zero, mem_ready;
   logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
   logic       alu_src_a, ext_sel, retire, illegal;
   logic [1:0] pc_src, alu_src_b;
   logic [2:0] alu_ctl;
   logic [3:0] state_o;

   always #5 clk = ~clk;

   multicycle_ctrl #(.OPW(6), .STW(4)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .pc_en(pc_en), .pc_src(pc_src), .iord(iord),
      .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_ctl(alu_ctl), .ext_sel(ext_sel),
      .retire(retire), .illegal(illegal), .state_o(state_o)
   );

   typedef struct {
      logic       rst;
      logic [5:0] op, fn;
      logic       zero, mr;
      logic [3:0] st;
      logic       pc_en;
      logic [1:0] pc_src;
      logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_ctl;
      logic       ext_sel, retire, illegal;
   } cyc_t;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, ORI = 6'b001101;
   localparam logic [5:0] JMP = 6'b000010;

   cyc_t q[$];
   cyc_t cur;
   bit   cur_valid = 1'b0;
   int   n_checks = 0, n_fail = 0, cyc_no = 0;
   int   exp_retires = 0, dut_retires = 0;

   wire [21:0] dut_vec = {state_o, pc_en, pc_src, iord, mem_write, ir_write, reg_dst,
                          mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_ctl, ext_sel,
                          retire, illegal};

   function automatic logic [21:0] pack(input cyc_t c);
      return {c.st, c.pc_en, c.pc_src, c.iord, c.mem_write, c.ir_write, c.reg_dst,
              c.mem_to_reg, c.reg_write, c.alu_src_a, c.alu_src_b, c.alu_ctl, c.ext_sel,
              c.retire, c.illegal};
   endfunction

   // A cycle in state st with every output at its default value
   function automatic cyc_t new_cyc(input logic [3:0] st, input logic [5:0] op,
                                    input logic [5:0] fn);
      cyc_t c;
      c.rst = 1'b0; c.op = op; c.fn = fn;
      c.zero = 1'($urandom); c.mr = 1'($urandom);
      c.st = st; c.pc_en = 1'b0; c.pc_src = 2'b00; c.iord = 1'b0; c.mem_write = 1'b0;
      c.ir_write = 1'b0; c.reg_dst = 1'b0; c.mem_to_reg = 1'b0; c.reg_write = 1'b0;
      c.alu_src_a = 1'b0; c.alu_src_b = 2'b00; c.alu_ctl = 3'b010; c.ext_sel = 1'b1;
      c.retire = 1'b0; c.illegal = 1'b0;
      return c;
   endfunction

   function automatic bit op_legal(input logic [5:0] op);
      return op == LW || op == SW || op == RT || op == BEQ || op == ADDI || op == ORI ||
             op == JMP;
   endfunction

   function automatic bit fn_ctl(input logic [5:0] fn, output logic [2:0] ctl);
      ctl = 3'b010;
      case (fn)
         6'b100000: ctl = 3'b010;
         6'b100010: ctl = 3'b110;
         6'b100100: ctl = 3'b000;
         6'b100101: ctl = 3'b001;
         6'b101010: ctl = 3'b111;
         default:   return 1'b0;
      endcase
      return 1'b1;
   endfunction

   task automatic push(input cyc_t c);
      if (c.retire) exp_retires++;
      q.push_back(c);
   endtask

   task automatic add_fetch(input int stalls);
      cyc_t c;
      for (int i = 0; i < stalls; i++) begin
         c = new_cyc(4'd0, 6'($urandom), 6'($urandom));
         c.mr = 1'b0; c.alu_src_b = 2'b01;
         push(c);
      end
      c = new_cyc(4'd0, 6'($urandom), 6'($urandom));
      c.mr = 1'b1; c.alu_src_b = 2'b01; c.pc_en = 1'b1; c.ir_write = 1'b1;
      push(c);
   endtask

   task automatic add_instr(input logic [5:0] op, input logic [5:0] fn, input int fstall,
                            input int mstall, input logic z);
      cyc_t c;
      logic [2:0] ctl;
      add_fetch(fstall);
      c = new_cyc(4'd1, op, fn); c.alu_src_b = 2'b11;
      if (!op_legal(op)) begin
         c.illegal = 1'b1; push(c); return;
      end
      push(c);
      if (op == LW || op == SW) begin
         c = new_cyc(4'd2, op, fn); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; push(c);
         for (int i = 0; i <= mstall; i++) begin
            c = new_cyc((op == LW) ? 4'd3 : 4'd5, op, fn);
            c.iord = 1'b1; c.mr = (i == mstall);
            if (op == SW) begin
               c.mem_write = 1'b1; c.retire = c.mr;
            end
            push(c);
         end
         if (op == LW) begin
            c = new_cyc(4'd4, op, fn);
            c.mem_to_reg = 1'b1; c.reg_write = 1'b1; c.retire = 1'b1; push(c);
         end
      end else if (op == RT) begin
         c = new_cyc(4'd6, op, fn); c.alu_src_a = 1'b1;
         if (!fn_ctl(fn, ctl)) begin
            c.illegal = 1'b1; push(c); return;
         end
         c.alu_ctl = ctl; push(c);
         c = new_cyc(4'd7, op, fn);
         c.reg_dst = 1'b1; c.reg_write = 1'b1; c.retire = 1'b1; push(c);
      end else if (op == BEQ) begin
         c = new_cyc(4'd8, op, fn);
         c.alu_src_a = 1'b1; c.alu_ctl = 3'b110; c.pc_src = 2'b01;
         c.zero = z; c.pc_en = z; c.retire = 1'b1; push(c);
      end else if (op == ADDI || op == ORI) begin
         c = new_cyc(4'd9, op, fn); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
         c.alu_ctl = (op == ORI) ? 3'b001 : 3'b010; c.ext_sel = (op != ORI); push(c);
         c = new_cyc(4'd10, op, fn); c.reg_write = 1'b1; c.retire = 1'b1;
         c.alu_ctl = (op == ORI) ? 3'b001 : 3'b010; c.ext_sel = (op != ORI); push(c);
      end else begin
         c = new_cyc(4'd11, op, fn);
         c.pc_src = 2'b10; c.pc_en = 1'b1; c.retire = 1'b1; push(c);
      end
   endtask

   task automatic pin(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   function automatic int q_retires();
      int n = 0;
      foreach (q[i]) n += int'(q[i].retire);
      return n;
   endfunction

   task automatic step(input cyc_t c);
      rst = c.rst; opcode = c.op; funct = c.fn; zero = c.zero; mem_ready = c.mr;
      cur = c; cur_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic play();
      while (q.size() > 0) step(q.pop_front());
   endtask

   initial begin
      cyc_t c;
      logic [5:0] op, fn;
      int sel;
      fork
         forever begin
            @(negedge clk);
            if (cur_valid) begin
               cyc_no++;
               n_checks++;
               if (dut_vec !== pack(cur)) begin
                  n_fail++;
                  $display("FAIL cycle %0d outputs: got st=%0d vec=%h, expected st=%0d vec=%h",
                           cyc_no, state_o, dut_vec, cur.st, pack(cur));
               end
               if (retire === 1'b1) dut_retires++;
            end
         end
      join_none

      rst = 1'b1; opcode = 6'h3f; funct = 6'h00; zero = 1'b1; mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      pin("reset_state", int'(state_o), 0);
      pin("reset_pc_en", int'(pc_en), 0);
      pin("reset_ir_write", int'(ir_write), 0);

      // add, no stalls
      add_instr(RT, 6'b100000, 0, 0, 1'b0);
      pin("add_len", q.size(), 4);
      pin("add_states", int'({q[0].st, q[1].st, q[2].st, q[3].st}), 'h0167);
      pin("add_retires", q_retires(), 1);
      play();

      // lw with two MEMRD stalls
      add_instr(LW, 6'h00, 0, 2, 1'b0);
      pin("lw_len", q.size(), 7);
      pin("lw_states", int'({q[0].st, q[1].st, q[2].st, q[3].st, q[4].st, q[5].st, q[6].st}),
          'h0123334);
      pin("lw_wb", int'({q[6].mem_to_reg, q[6].reg_write}), 3);
      play();

      add_instr(BEQ, 6'h00, 0, 0, 1'b1);
      pin("beq_taken_len", q.size(), 3);
      pin("beq_taken_pc", int'({q[2].pc_src, q[2].pc_en}), 3);
      play();
      add_instr(BEQ, 6'h00, 0, 0, 1'b0);
      pin("beq_not_taken_pc", int'({q[2].pc_src, q[2].pc_en}), 2);
      play();

      add_instr(ORI, 6'h15, 0, 0, 1'b0);
      pin("ori_iexec", int'({q[2].ext_sel, q[2].alu_ctl}), 1);
      pin("ori_iwb", int'({q[3].ext_sel, q[3].alu_ctl}), 1);
      play();
      add_instr(ADDI, 6'h2a, 1, 0, 1'b0);
      pin("addi_iexec", int'({q[3].ext_sel, q[3].alu_ctl}), 10);
      play();

      add_instr(6'b111111, 6'h00, 0, 0, 1'b0);
      pin("illegal_op_len", q.size(), 2);
      add_instr(RT, 6'b000111, 0, 0, 1'b0);
      pin("illegal_fn_len", q.size(), 5);
      pin("illegal_retires", q_retires(), 0);
      play();

      // Reset held for 3 cycles while sw is stalled in MEMWR
      add_fetch(0);
      c = new_cyc(4'd1, SW, 6'h00); c.alu_src_b = 2'b11; push(c);
      c = new_cyc(4'd2, SW, 6'h00); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; push(c);
      c = new_cyc(4'd5, SW, 6'h00); c.iord = 1'b1; c.mem_write = 1'b1; c.mr = 1'b0; push(c);
      c = new_cyc(4'd5, SW, 6'h00); c.iord = 1'b1; c.rst = 1'b1; c.mr = 1'b1; push(c);
      for (int i = 0; i < 2; i++) begin
         c = new_cyc(4'd0, 6'($urandom), 6'($urandom));
         c.alu_src_b = 2'b01; c.rst = 1'b1; push(c);
      end
      pin("rst_mid_sw_len", q.size(), 7);
      play();
      add_instr(JMP, 6'h00, 0, 0, 1'b0);
      play();

      // Reset in DECODE of an undefined opcode must suppress the illegal pulse
      add_fetch(0);
      c = new_cyc(4'd1, 6'b111111, 6'h00); c.alu_src_b = 2'b11; c.rst = 1'b1; push(c);
      add_instr(SW, 6'h00, 0, 0, 1'b0);
      play();

      for (int n = 0; n < 300; n++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            0: op = LW;
            1: op = SW;
            2, 3: op = RT;
            4: op = BEQ;
            5: op = ADDI;
            6: op = ORI;
            7: op = JMP;
            8: op = 6'($urandom);
            default: op = 6'b111111;
         endcase
         case ($urandom_range(0, 5))
            0: fn = 6'b100000;
            1: fn = 6'b100010;
            2: fn = 6'b100100;
            3: fn = 6'b100101;
            4: fn = 6'b101010;
            default: fn = 6'($urandom);
         endcase
         add_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
         play();
      end

      cur_valid = 1'b0;
      pin("retire_count", dut_retires, exp_retires);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
